// File: rtl/mem_arb_pkg.sv
// Shared types for the byte-serialising memory arbiter: FSM states, len
// encoding, the latched transfer descriptor and byte-lane helpers.
package mem_arb_pkg;

  localparam int ARCH_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // len is byte count minus one; the byte index inside a word uses the same code.
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  len;
    logic [31:0] wdata;
  } xfer_t;

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      LEN_1B:  byte_lane = w[7:0];
      LEN_2B:  byte_lane = w[15:8];
      LEN_3B:  byte_lane = w[23:16];
      LEN_4B:  byte_lane = w[31:24];
      default: byte_lane = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    set_lane = w;
    case (idx)
      LEN_1B:  set_lane[7:0]   = b;
      LEN_2B:  set_lane[15:8]  = b;
      LEN_3B:  set_lane[23:16] = b;
      LEN_4B:  set_lane[31:24] = b;
      default: set_lane        = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
// Latency: purely combinational. Backpressure: none; caller samples only when it can accept.
module mem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory port between fetch (0) and data (1), serialising 1-4 byte LE transfers.
// Latency: strobes 1 cycle after grant, done 1 cycle after the final ready.
// Backpressure: each byte cycle holds address/strobes/data until memory returns ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARCH_SIZE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        len0,
  input  logic [1:0]        len1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              done0,
  output logic              done1,
  input  logic              ready,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [7:0]        read_value,
  output logic              write,
  output logic [7:0]        write_value
);

  state_t            state_q, state_d;
  logic              grant_valid, grant_id;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  xfer_t             xfer_q, xfer_d, sel_xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        byte_idx_q, byte_idx_d, nxt_idx;
  logic              last_byte;
  logic [31:0]       rd_word;

  logic [ADDR_W-1:0] address_d;
  logic              read_d, write_d;
  logic [7:0]        write_value_d;
  logic              done0_d, done1_d;
  logic [31:0]       rdata0_d, rdata1_d;

  mem_arb_rr u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_xfer.we    = grant_id ? we1    : we0;
    sel_xfer.len   = grant_id ? len1   : len0;
    sel_xfer.wdata = grant_id ? wdata1 : wdata0;
    sel_addr       = grant_id ? addr1  : addr0;
  end

  assign last_byte = (byte_idx_q == xfer_q.len);
  assign nxt_idx   = byte_idx_q + 2'd1;
  assign rd_word   = set_lane(gnt_q ? rdata1 : rdata0, byte_idx_q, read_value);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, so nothing pre-empts a transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = XFER;
      XFER:    if (ready && last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for every registered output and datapath register
  always_comb begin
    gnt_d         = gnt_q;
    xfer_d        = xfer_q;
    byte_idx_d    = byte_idx_q;
    last_grant_d  = last_grant_q;
    address_d     = address;
    read_d        = read;
    write_d       = write;
    write_value_d = write_value;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_d         = grant_id;
          xfer_d        = sel_xfer;
          byte_idx_d    = 2'd0;
          address_d     = sel_addr;
          read_d        = ~sel_xfer.we;
          write_d       = sel_xfer.we;
          write_value_d = sel_xfer.wdata[7:0];
          if (grant_id) begin
            rdata1_d = '0;
          end else begin
            rdata0_d = '0;
          end
        end
      end
      XFER: begin
        if (ready) begin
          if (!xfer_q.we) begin
            if (gnt_q) begin
              rdata1_d = rd_word;
            end else begin
              rdata0_d = rd_word;
            end
          end
          if (last_byte) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            done0_d = ~gnt_q;
            done1_d = gnt_q;
          end else begin
            // Strobes stay up so the next byte cycle starts immediately
            byte_idx_d    = nxt_idx;
            address_d     = address + ADDR_W'(1);
            write_value_d = byte_lane(xfer_q.wdata, nxt_idx);
          end
        end
      end
      DONE: begin
        last_grant_d = gnt_q;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      xfer_q       <= '0;
      byte_idx_q   <= 2'd0;
      address      <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      write_value  <= 8'h00;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      xfer_q       <= xfer_d;
      byte_idx_q   <= byte_idx_d;
      address      <= address_d;
      read         <= read_d;
      write        <= write_d;
      write_value  <= write_value_d;
      done0        <= done0_d;
      done1        <= done1_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transfers plus hand-written
// sequences for contention, ignored ready and reset in the middle of a transfer.
module tb_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [1:0]  len0, len1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1;
  logic        ready;
  logic [15:0] address;
  logic        read, write;
  logic [7:0]  read_value, write_value;

  mem_arbiter #(.ADDR_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .len0        (len0),
    .len1        (len1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .done0       (done0),
    .done1       (done1),
    .ready       (ready),
    .address     (address),
    .read        (read),
    .read_value  (read_value),
    .write       (write),
    .write_value (write_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
  } ent_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [15:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
  } vec_t;

  // Written only by the memory model
  logic [7:0] mem [0:65535];
  ent_t       log_q [$];
  int         unstable_cnt;
  int         both_done_cnt;

  // Written only by the main sequence
  int          ready_delay;
  logic        idle_ready;
  int          checks;
  int          failures;
  logic [31:0] exp_rd0, exp_rd1;

  // Memory model: answers each byte cycle after ready_delay stall cycles, logs accepted bytes
  initial begin
    int          wait_cnt;
    bit          prev_stall;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wv;
    logic        prev_rd, prev_wr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;
    mem[16'hFFFF] = 8'hA5;
    mem[16'h0000] = 8'h5A;
    ready = 1'b0;
    read_value = 8'hCC;
    unstable_cnt = 0;
    both_done_cnt = 0;
    wait_cnt = 0;
    prev_stall = 0;
    prev_addr = '0;
    prev_wv = '0;
    prev_rd = 0;
    prev_wr = 0;
    forever begin
      @(negedge clock);
      if (done0 && done1) both_done_cnt++;
      if (read || write) begin
        if (prev_stall && (address !== prev_addr || write_value !== prev_wv ||
                           read !== prev_rd || write !== prev_wr))
          unstable_cnt++;
        if (wait_cnt >= ready_delay) begin
          ready = 1'b1;
          wait_cnt = 0;
          prev_stall = 0;
          if (write) mem[address] = write_value;
          read_value = mem[address];
          log_q.push_back('{a: address, w: write, d: (write ? write_value : mem[address])});
        end else begin
          ready = 1'b0;
          read_value = 8'hCC;
          wait_cnt++;
          prev_stall = 1;
          prev_addr = address;
          prev_wv = write_value;
          prev_rd = read;
          prev_wr = write;
        end
      end else begin
        ready = idle_ready;
        read_value = 8'hCC;
        wait_cnt = 0;
        prev_stall = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          lat;
    int          base;
    int          ust;
    bit          seen;
    logic        ok;
    logic [31:0] w;
    logic [15:0] ea;
    base = log_q.size();
    ust = unstable_cnt;
    ready_delay = v.delay;
    @(negedge clock);
    if (v.id) begin
      req1 = 1; we1 = v.we; addr1 = v.addr; len1 = v.len; wdata1 = v.wdata;
    end else begin
      req0 = 1; we0 = v.we; addr0 = v.addr; len0 = v.len; wdata0 = v.wdata;
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        // Change the request inputs after the grant: the latched copy must be used
        if (v.id) begin
          we1 = ~v.we; addr1 = 16'h1234; len1 = ~v.len; wdata1 = ~v.wdata;
        end else begin
          we0 = ~v.we; addr0 = 16'h1234; len0 = ~v.len; wdata0 = ~v.wdata;
        end
      end
      seen = v.id ? done1 : done0;
    end
    req0 = 0;
    req1 = 0;
    check($sformatf("v%0d_done_seen", n), {31'd0, seen}, 32'd1);
    if (v.id) exp_rd1 = v.exp_rdata; else exp_rd0 = v.exp_rdata;
    check($sformatf("v%0d_latency", n), lat, 1 + (int'(v.len) + 1) * (v.delay + 1));
    check($sformatf("v%0d_rdata0", n), rdata0, exp_rd0);
    check($sformatf("v%0d_rdata1", n), rdata1, exp_rd1);
    check($sformatf("v%0d_byte_count", n), log_q.size() - base, int'(v.len) + 1);
    ok = 1;
    w = v.we ? v.wdata : v.exp_rdata;
    for (int k = 0; k <= int'(v.len); k++) begin
      ea = v.addr + 16'(k);
      if (base + k >= log_q.size()) ok = 0;
      else if (log_q[base+k].a !== ea || log_q[base+k].w !== v.we ||
               log_q[base+k].d !== w[8*k +: 8]) ok = 0;
    end
    check($sformatf("v%0d_byte_cycles", n), {31'd0, ok}, 32'd1);
    check($sformatf("v%0d_stable_while_stalled", n), unstable_cnt - ust, 0);
    @(negedge clock);
    check($sformatf("v%0d_done_one_cycle", n), {31'd0, done0 | done1}, 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    int   bad;
    int   n;
    int   cyc;
    int   base;
    logic [3:0] ids;
    logic ok;

    vecs[0] = '{id: 1'b0, we: 1'b0, addr: 16'h0100, len: 2'd3, wdata: 32'h0, delay: 0, exp_rdata: 32'h44332211};
    vecs[1] = '{id: 1'b1, we: 1'b1, addr: 16'h0020, len: 2'd1, wdata: 32'h0000BEEF, delay: 3, exp_rdata: 32'h0};
    vecs[2] = '{id: 1'b0, we: 1'b0, addr: 16'hFFFF, len: 2'd1, wdata: 32'h0, delay: 0, exp_rdata: 32'h00005AA5};
    vecs[3] = '{id: 1'b1, we: 1'b0, addr: 16'h0020, len: 2'd1, wdata: 32'h0, delay: 1, exp_rdata: 32'h0000BEEF};
    vecs[4] = '{id: 1'b0, we: 1'b1, addr: 16'h0200, len: 2'd3, wdata: 32'hDEADBEEF, delay: 0, exp_rdata: 32'h0};
    vecs[5] = '{id: 1'b1, we: 1'b0, addr: 16'h0201, len: 2'd2, wdata: 32'h0, delay: 2, exp_rdata: 32'h00DEADBE};
    vecs[6] = '{id: 1'b0, we: 1'b0, addr: 16'h0103, len: 2'd0, wdata: 32'h0, delay: 0, exp_rdata: 32'h00000044};

    checks = 0;
    failures = 0;
    ready_delay = 0;
    idle_ready = 1'b0;
    we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    wdata0 = '0; wdata1 = '0;
    do_reset();

    check("reset_address", {16'd0, address}, 32'd0);
    check("reset_read", {31'd0, read}, 32'd0);
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_write_value", {24'd0, write_value}, 32'd0);
    check("reset_done", {30'd0, done1, done0}, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_rdata1", rdata1, 32'd0);

    // Ready pulses while idle must not start anything
    idle_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (done0 || done1 || read || write) bad++;
    end
    idle_ready = 1'b0;
    check("idle_ready_ignored", bad, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Contention from reset with both requests held: grants alternate 0,1,0,1
    do_reset();
    ready_delay = 0;
    base = log_q.size();
    we0 = 0; addr0 = 16'h0100; len0 = 2'd0;
    we1 = 0; addr1 = 16'h0101; len1 = 2'd0;
    req0 = 1; req1 = 1;
    n = 0;
    cyc = 0;
    ids = '0;
    while (n < 4 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (done0) begin ids[n] = 1'b0; n++; end
      else if (done1) begin ids[n] = 1'b1; n++; end
    end
    req0 = 0;
    req1 = 0;
    check("contend_done_count", n, 4);
    check("contend_grant_order", {28'd0, ids}, 32'b1010);
    ok = (log_q.size() >= base + 4);
    if (ok) ok = (log_q[base].a == 16'h0100) && (log_q[base+1].a == 16'h0101) &&
                 (log_q[base+2].a == 16'h0100) && (log_q[base+3].a == 16'h0101);
    check("contend_addresses", {31'd0, ok}, 32'd1);
    check("contend_rdata0", rdata0, 32'h00000011);
    check("contend_rdata1", rdata1, 32'h00000022);
    repeat (3) @(negedge clock);

    // Reset during the second byte of a 4-byte read
    do_reset();
    ready_delay = 0;
    we0 = 0; addr0 = 16'h0100; len0 = 2'd3;
    req0 = 1;
    cyc = 0;
    while (!(read && address == 16'h0101) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("midrst_reached_byte2", {31'd0, read && address == 16'h0101}, 32'd1);
    reset_n = 1'b0;
    req0 = 0;
    @(negedge clock);
    check("midrst_read_dropped", {31'd0, read}, 32'd0);
    check("midrst_no_done", {31'd0, done0}, 32'd0);
    check("midrst_rdata0_cleared", rdata0, 32'd0);
    reset_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (done0 || done1 || read || write) bad++;
    end
    check("midrst_quiet_after", bad, 0);
    run_vec(vecs[0], 7);

    check("never_dual_done", both_done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
